// File: rtl/nibble_serial_alu.sv
// nibble_serial_alu: 16-bit add/subtract that runs through one 4-bit adder,
// one nibble per cycle, least-significant nibble first.
// Ports:
//   clk, rst          rising-edge clock, async active-high reset
//   start, sub, a, b  request (taken only while idle), op select, operands
//   busy, done        operation in progress / one-cycle completion pulse
//   result            16-bit sum or difference, held until next completion
//   c/v/n/z_flag      carry (no-borrow on sub), signed overflow, sign, zero

// adder_4bit: 4-bit ripple adder with carry-in, carry-out, signed overflow
// and group propagate/generate.
module adder_4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       C,
    output logic [3:0] Sum,
    output logic       Cout,
    output logic       ovfl,
    output logic       P,
    output logic       G
);
    logic [4:0] w_full;

    assign w_full = 5'(A) + 5'(B) + 5'(C);
    assign Sum    = w_full[3:0];
    assign Cout   = w_full[4];
    // Overflow when both operands share a sign that the sum does not.
    assign ovfl   = (A[3] == B[3]) && (Sum[3] != A[3]);
    assign P      = &(A ^ B);
    assign G      = (A[3] & B[3])
                  | ((A[3] ^ B[3]) & A[2] & B[2])
                  | ((A[3] ^ B[3]) & (A[2] ^ B[2]) & A[1] & B[1])
                  | ((A[3] ^ B[3]) & (A[2] ^ B[2]) & (A[1] ^ B[1]) & A[0] & B[0]);
endmodule

module nibble_serial_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        c_flag,
    output logic        v_flag,
    output logic        n_flag,
    output logic        z_flag
);
    localparam int unsigned W  = 16;
    localparam int unsigned NW = 4;

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [1:0]      r_idx;
    logic            r_cy;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_work;
    logic [W-1:0]    r_result;
    logic            r_done;
    logic            r_c;
    logic            r_v;
    logic            r_n;
    logic            r_z;
    logic            w_load;
    logic            w_last;
    logic [NW-1:0]   w_a_nib;
    logic [NW-1:0]   w_b_nib;
    logic [NW-1:0]   w_sum;
    logic            w_cout;
    logic            w_ovfl;
    logic [W-1:0]    w_assembled;

    // Select the operand nibbles addressed by the current index.
    assign w_a_nib = NW'(r_a >> {r_idx, 2'b00});
    assign w_b_nib = NW'(r_b >> {r_idx, 2'b00});

    adder_4bit u_adder (
        .A    (w_a_nib),
        .B    (w_b_nib),
        .C    (r_cy),
        .Sum  (w_sum),
        .Cout (w_cout),
        .ovfl (w_ovfl),
        .P    (),
        .G    ()
    );

    // Final nibble is merged directly with the three already written.
    assign w_assembled = {w_sum, r_work[11:0]};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state and control decode.
    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load     = 1'b1;
                    w_state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == 2'd3) begin
                    w_last     = 1'b1;
                    w_state_nx = S_IDLE;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Operand latch, nibble iteration and completion registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx    <= 2'd0;
            r_cy     <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_work   <= '0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_n      <= 1'b0;
            r_z      <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_load) begin
                r_a   <= a;
                r_b   <= sub ? ~b : b;
                r_cy  <= sub;
                r_idx <= 2'd0;
            end else if (r_state == S_RUN) begin
                r_work[{r_idx, 2'b00} +: NW] <= w_sum;
                r_cy  <= w_cout;
                r_idx <= r_idx + 2'd1;
                if (w_last) begin
                    r_result <= w_assembled;
                    r_c      <= w_cout;
                    r_v      <= w_ovfl;
                    r_n      <= w_sum[3];
                    r_z      <= (w_assembled == '0);
                end
            end
        end
    end

    assign busy   = (r_state == S_RUN);
    assign done   = r_done;
    assign result = r_result;
    assign c_flag = r_c;
    assign v_flag = r_v;
    assign n_flag = r_n;
    assign z_flag = r_z;
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Self-checking bench for nibble_serial_alu: directed vector table, random
// operations against an arithmetic reference model, and hand-written
// sequences for back-to-back starts and mid-operation reset.
module tb_nibble_serial_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        c_flag;
    logic        v_flag;
    logic        n_flag;
    logic        z_flag;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nibble_serial_alu dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .c_flag (c_flag),
        .v_flag (v_flag),
        .n_flag (n_flag),
        .z_flag (z_flag)
    );

    typedef struct {
        logic        sub;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  cvnz;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: plain unsigned and signed arithmetic on the operands.
    task automatic model(input logic s, input logic [15:0] x, input logic [15:0] y,
                         output logic [15:0] res, output logic [3:0] cvnz);
        int ux, uy, sx, sy, uf, sf;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            uf = ux - uy;
            sf = sx - sy;
            c  = (ux >= uy);
        end else begin
            uf = ux + uy;
            sf = sx + sy;
            c  = (uf > 65535);
        end
        res  = 16'(uf);
        v    = (sf > 32767) || (sf < -32768);
        cvnz = {c, v, res[15], res == 16'h0000};
    endtask

    // Issue one operation from idle; returns cycles from acceptance to done.
    // Operand inputs are scrambled after acceptance to check they are latched.
    task automatic run_op(input logic s, input logic [15:0] x, input logic [15:0] y,
                          output int lat);
        @(negedge clk);
        sub = s; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        sub = 1'($urandom);
        a = 16'($urandom);
        b = 16'($urandom);
        chk("busy_after_accept", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic s, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] eres,
                            input logic [3:0] ecvnz);
        int lat;
        run_op(s, x, y, lat);
        chk({name, "_latency"}, 32'(lat), 32'd4);
        chk({name, "_busy_in_done"}, 32'(busy), 32'd0);
        chk({name, "_result"}, 32'(result), 32'(eres));
        chk({name, "_cvnz"}, 32'({c_flag, v_flag, n_flag, z_flag}), 32'(ecvnz));
        @(negedge clk);
        chk({name, "_done_one_cycle"}, 32'(done), 32'd0);
        chk({name, "_result_hold"}, 32'(result), 32'(eres));
    endtask

    vec_t vecs[6];

    initial begin
        logic [15:0] mres;
        logic [3:0]  mcvnz;
        int          lat;
        int          done_seen;

        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0110};
        vecs[1] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b1001};
        vecs[2] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1001};
        vecs[3] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
        vecs[4] = '{1'b1, 16'h0000, 16'h0001, 16'hFFFF, 4'b0010};
        vecs[5] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1101};

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_flags", 32'({c_flag, v_flag, n_flag, z_flag}), 32'd0);
        rst = 1'b0;

        // Directed vectors.
        for (int i = 0; i < 6; i++)
            check_op($sformatf("vec%0d", i), vecs[i].sub, vecs[i].a, vecs[i].b,
                     vecs[i].res, vecs[i].cvnz);

        // Random operations against the model.
        for (int i = 0; i < 40; i++) begin
            logic        rs;
            logic [15:0] ra, rb;
            rs = 1'($urandom);
            ra = 16'($urandom);
            rb = (i % 8 == 0) ? ra : 16'($urandom);
            model(rs, ra, rb, mres, mcvnz);
            check_op($sformatf("rand%0d", i), rs, ra, rb, mres, mcvnz);
        end

        // Start while busy is ignored; start in the done cycle is accepted.
        @(negedge clk);
        sub = 1'b0; a = 16'h0003; b = 16'h0004; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 16'h1111; b = 16'h1111;
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("b2b_first_latency", 32'(lat), 32'd4);
        chk("b2b_first_result", 32'(result), 32'h0007);
        a = 16'h00F0; b = 16'h0010;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_second_busy", 32'(busy), 32'd1);
        lat = 0;
        while (!done && lat < 10) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk("b2b_second_latency", 32'(lat), 32'd4);
        chk("b2b_second_result", 32'(result), 32'h0100);
        chk("b2b_second_cvnz", 32'({c_flag, v_flag, n_flag, z_flag}), 32'd0);

        // Reset two cycles into an operation.
        @(negedge clk);
        sub = 1'b0; a = 16'hAAAA; b = 16'h5555; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_result", 32'(result), 32'd0);
        chk("midrst_flags", 32'({c_flag, v_flag, n_flag, z_flag}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        chk("midrst_no_done", 32'(done_seen), 32'd0);
        check_op("after_rst", 1'b0, 16'h0001, 16'h0001, 16'h0002, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time limit.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
